// File: rtl/burst_sram_pkg.sv
// Shared types and constants for the burst SRAM controller and its memory.
package burst_sram_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WCMPL = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // A zero length field encodes the maximum burst of 2^LEN_W beats.
  function automatic logic [LEN_W:0] len_to_beats(input logic [LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  endfunction
endpackage

// File: rtl/burst_sram_ctrl_if.sv
// Host request/write/read streams plus the SRAM command bus of the controller.
interface burst_sram_ctrl_if;
  import burst_sram_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. The host holds req_valid (and its payload) until req_ready is seen;
  // wr_data is consumed only on wr_valid & wr_ready. rd_valid has no ready.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [LEN_W-1:0]  sram_burst_len;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  state_t            dbg_state;

  // System side: host streams and the memory's read data.
  modport master (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, sram_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  sram_cs, sram_we, sram_addr, sram_burst_len, sram_wdata, dbg_state
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, sram_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done,
    output sram_cs, sram_we, sram_addr, sram_burst_len, sram_wdata, dbg_state
  );
endinterface

// File: rtl/burst_mode_sram.sv
// 16x8 SRAM: writes on cs&we, registered read data one cycle after cs&~we.
module burst_mode_sram
  import burst_sram_pkg::*;
(
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];

  // Storage array and registered read port.
  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= data_in;
    if (cs && !we) data_out <= mem[addr];
  end
endmodule

// File: rtl/burst_sram_ctrl.sv
// Burst initiator: one host request at a time, issued as per-beat SRAM commands.
module burst_sram_ctrl
  import burst_sram_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  burst_sram_ctrl_if.slave bus
);
  state_t            state, state_nxt;
  logic [LEN_W:0]    cnt;        // beats still to issue, including the current one
  logic [ADDR_W-1:0] ptr;        // next address to put on the SRAM bus
  logic              rd_valid_q;
  logic              last;

  assign last = (cnt == (LEN_W+1)'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: writes advance on accepted beats, reads every cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = bus.req_we ? WRITE : READ;
      WRITE:   if (bus.wr_valid && last) state_nxt = WCMPL;
      WCMPL:   state_nxt = IDLE;
      READ:    if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded host outputs; read data is only shown while it is valid.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.wr_ready  = (state == WRITE);
    bus.done      = (state == WCMPL) || (state == DRAIN);
    bus.rd_valid  = rd_valid_q;
    bus.rd_data   = rd_valid_q ? bus.sram_rdata : '0;
    bus.dbg_state = state;
  end

  // Beat counter and address pointer; a read's first command leaves at accept,
  // so its pointer starts one past the request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ptr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cnt <= len_to_beats(bus.req_len);
          ptr <= bus.req_we ? bus.req_addr : bus.req_addr + ADDR_W'(1);
        end
        WRITE: if (bus.wr_valid) begin
          cnt <= cnt - (LEN_W+1)'(1);
          ptr <= ptr + ADDR_W'(1);
        end
        READ: if (!last) begin
          cnt <= cnt - (LEN_W+1)'(1);
          ptr <= ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered SRAM command bus; cs drops unless a command is issued this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sram_cs        <= 1'b0;
      bus.sram_we        <= 1'b0;
      bus.sram_addr      <= '0;
      bus.sram_burst_len <= '0;
      bus.sram_wdata     <= '0;
    end else begin
      bus.sram_cs <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.sram_burst_len <= bus.req_len;
          if (!bus.req_we) begin
            bus.sram_cs   <= 1'b1;
            bus.sram_we   <= 1'b0;
            bus.sram_addr <= bus.req_addr;
          end
        end
        WRITE: if (bus.wr_valid) begin
          bus.sram_cs    <= 1'b1;
          bus.sram_we    <= 1'b1;
          bus.sram_addr  <= ptr;
          bus.sram_wdata <= bus.wr_data;
        end
        READ: if (!last) begin
          bus.sram_cs   <= 1'b1;
          bus.sram_we   <= 1'b0;
          bus.sram_addr <= ptr;
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after each read command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= bus.sram_cs & ~bus.sram_we;
  end
endmodule
